// File: rtl/half_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : half_adder_if
// Purpose  : Operand/result handshake bundle for the half_adder lane array.
// Revision : 1.0 - initial release
// ============================================================================
interface half_adder_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a, b, in_valid, out_ready,
    input  in_ready, sum, carry, out_valid
  );

  modport slave (
    input  a, b, in_valid, out_ready,
    output in_ready, sum, carry, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/half_adder.sv
`default_nettype none
// ============================================================================
// Module   : half_adder
// Purpose  : Registered array of independent half adders with valid/ready
//            handshake and wrap-around op/carry statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module half_adder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  half_adder_if.slave           bus,
  output logic      [CNT_W-1:0] op_count,
  output logic      [CNT_W-1:0] carry_count
);

  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] lane_sum;
  logic [WIDTH-1:0] lane_carry;

  logic [WIDTH-1:0] sum_q,         sum_d;
  logic [WIDTH-1:0] carry_q,       carry_d;
  logic             out_valid_q,   out_valid_d;
  logic [CNT_W-1:0] op_count_q,    op_count_d;
  logic [CNT_W-1:0] carry_count_q, carry_count_d;

  logic in_ready;
  logic accept;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_lanes
      assign lane_sum[i]   = bus.a[i] ^ bus.b[i];
      assign lane_carry[i] = bus.a[i] & bus.b[i];
    end
  endgenerate

  // Ready depends only on the output stage, never on in_valid.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    sum_d         = sum_q;
    carry_d       = carry_q;
    out_valid_d   = out_valid_q;
    op_count_d    = op_count_q;
    carry_count_d = carry_count_q;
    if (accept) begin
      sum_d       = lane_sum;
      carry_d     = lane_carry;
      out_valid_d = 1'b1;
      op_count_d  = op_count_q + c_CNT_ONE;
      if (|lane_carry) begin
        carry_count_d = carry_count_q + c_CNT_ONE;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q         <= '0;
      carry_q       <= '0;
      out_valid_q   <= 1'b0;
      op_count_q    <= '0;
      carry_count_q <= '0;
    end else begin
      sum_q         <= sum_d;
      carry_q       <= carry_d;
      out_valid_q   <= out_valid_d;
      op_count_q    <= op_count_d;
      carry_count_q <= carry_count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.out_valid = out_valid_q;
  assign op_count      = op_count_q;
  assign carry_count   = carry_count_q;

endmodule
`default_nettype wire

// File: tb/tb_half_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_half_adder
// Purpose  : Directed self-checking bench for half_adder (1-lane and 4-lane).
// Revision : 1.0 - initial release
// ============================================================================
module tb_half_adder;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  logic [15:0] op1, cc1;
  logic [3:0]  op4, cc4;

  half_adder_if #(.WIDTH(1)) if1 ();
  half_adder_if #(.WIDTH(4)) if4 ();

  half_adder #(.WIDTH(1), .CNT_W(16)) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .bus         (if1.slave),
    .op_count    (op1),
    .carry_count (cc1)
  );

  half_adder #(.WIDTH(4), .CNT_W(4)) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .bus         (if4.slave),
    .op_count    (op4),
    .carry_count (cc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    if1.a = 1'b0; if1.b = 1'b0; if1.in_valid = 1'b0; if1.out_ready = 1'b1;
    if4.a = 4'h0; if4.b = 4'h0; if4.in_valid = 1'b0; if4.out_ready = 1'b1;

    // Reset state
    #3;
    check("rst_sum",       32'(if1.sum),       32'd0);
    check("rst_carry",     32'(if1.carry),     32'd0);
    check("rst_out_valid", 32'(if1.out_valid), 32'd0);
    check("rst_in_ready",  32'(if1.in_ready),  32'd1);
    check("rst_op_count",  32'(op1),           32'd0);
    tick();
    rst = 1'b0;

    // Truth table, one op per cycle
    if1.in_valid = 1'b1;
    if1.a = 1'b0; if1.b = 1'b0; tick();
    check("tt00_sum", 32'(if1.sum), 32'd0);
    check("tt00_carry", 32'(if1.carry), 32'd0);
    check("tt00_valid", 32'(if1.out_valid), 32'd1);
    if1.a = 1'b0; if1.b = 1'b1; tick();
    check("tt01_sum", 32'(if1.sum), 32'd1);
    check("tt01_carry", 32'(if1.carry), 32'd0);
    if1.a = 1'b1; if1.b = 1'b0; tick();
    check("tt10_sum", 32'(if1.sum), 32'd1);
    check("tt10_carry", 32'(if1.carry), 32'd0);
    if1.a = 1'b1; if1.b = 1'b1; tick();
    check("tt11_sum", 32'(if1.sum), 32'd0);
    check("tt11_carry", 32'(if1.carry), 32'd1);
    check("tt_op_count", 32'(op1), 32'd4);
    check("tt_carry_count", 32'(cc1), 32'd1);
    if1.in_valid = 1'b0; if1.a = 1'bx; if1.b = 1'bx;
    tick();
    check("drain_valid", 32'(if1.out_valid), 32'd0);
    check("drain_carry_hold", 32'(if1.carry), 32'd1);
    check("drain_op_count", 32'(op1), 32'd4);

    // Backpressure
    if1.in_valid = 1'b1; if1.a = 1'b1; if1.b = 1'b1; tick();
    check("bp_accept_carry", 32'(if1.carry), 32'd1);
    check("bp_op_count", 32'(op1), 32'd5);
    if1.out_ready = 1'b0; if1.a = 1'b0; if1.b = 1'b1;
    #1;
    check("bp_in_ready_low", 32'(if1.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_sum", 32'(if1.sum), 32'd0);
      check("bp_hold_carry", 32'(if1.carry), 32'd1);
      check("bp_hold_valid", 32'(if1.out_valid), 32'd1);
      check("bp_hold_op_count", 32'(op1), 32'd5);
      check("bp_hold_in_ready", 32'(if1.in_ready), 32'd0);
    end
    if1.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(if1.in_ready), 32'd1);
    tick();
    check("bp_release_sum", 32'(if1.sum), 32'd1);
    check("bp_release_carry", 32'(if1.carry), 32'd0);
    check("bp_release_valid", 32'(if1.out_valid), 32'd1);
    check("bp_release_op_count", 32'(op1), 32'd6);
    check("bp_release_carry_count", 32'(cc1), 32'd2);

    // Asynchronous reset mid-cycle while a result is pending
    if1.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(if1.out_valid), 32'd0);
    check("arst_sum", 32'(if1.sum), 32'd0);
    check("arst_op_count", 32'(op1), 32'd0);
    check("arst_carry_count", 32'(cc1), 32'd0);
    check("arst_in_ready", 32'(if1.in_ready), 32'd1);
    tick();
    rst = 1'b0;

    // Streaming: ten back-to-back ops; carries occur at i = 3 and i = 7
    if1.in_valid = 1'b1;
    if1.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic ea, eb;
      ea = i[0];
      eb = i[1];
      if1.a = ea; if1.b = eb;
      tick();
      check("stream_valid", 32'(if1.out_valid), 32'd1);
      check("stream_sum", 32'(if1.sum), 32'(ea ^ eb));
      check("stream_carry", 32'(if1.carry), 32'(ea & eb));
    end
    if1.in_valid = 1'b0;
    check("stream_op_count", 32'(op1), 32'd10);
    check("stream_carry_count", 32'(cc1), 32'd2);

    // Multi-lane
    if4.in_valid = 1'b1; if4.a = 4'b1100; if4.b = 4'b1010;
    tick();
    check("ml_sum", 32'(if4.sum), 32'b0110);
    check("ml_carry", 32'(if4.carry), 32'b1000);
    check("ml_op_count", 32'(op4), 32'd1);
    check("ml_carry_count", 32'(cc4), 32'd1);

    // Counter wrap with 4-bit counters: 16 more all-ones ops (17 total)
    if4.a = 4'hF; if4.b = 4'hF;
    for (int i = 0; i < 15; i++) tick();
    check("wrap16_op_count", 32'(op4), 32'd0);
    check("wrap16_carry_count", 32'(cc4), 32'd0);
    tick();
    if4.in_valid = 1'b0;
    check("wrap_sum", 32'(if4.sum), 32'h0);
    check("wrap_carry", 32'(if4.carry), 32'hF);
    check("wrap17_op_count", 32'(op4), 32'd1);
    check("wrap17_carry_count", 32'(cc4), 32'd1);
    tick();
    check("wrap_idle_valid", 32'(if4.out_valid), 32'd0);
    check("dut1_idle_op_count", 32'(op1), 32'd10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
